mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of mainMemory. It shares the single memory port between the instruction-fetch path (word reads only) and the load/store path (byte/half/word, read or write). Each memory access runs as a full request/send handshake, followed by a mandatory idle gap, because the memory's send output is edge-detected. Illegal requests are rejected and a hung access is timed out.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arb_rr.sv | 40 ++++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//----------------------------------------------------------------------
// mem_arbiter_pkg: shared encodings for the mainMemory arbiter (rev 1.0)
//----------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_ERR   = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [2:0] BHW_BYTE = 3'b001;
    localparam logic [2:0] BHW_HALF = 3'b010;
    localparam logic [2:0] BHW_WORD = 3'b100;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    function automatic logic [31:0] zext_data(input logic [2:0] bhw, input logic [31:0] d);
        case (bhw)
            BHW_BYTE: return {24'd0, d[7:0]};
            BHW_HALF: return {16'd0, d[15:0]};
            default:  return d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
//----------------------------------------------------------------------
// mem_arbiter_if: requester and mainMemory signals of the arbiter (rev 1.0)
//----------------------------------------------------------------------
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_adr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        i_err;
    logic        d_req;
    logic        d_wr_nrd;
    logic [2:0]  d_bhw;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        mem_request;
    logic [2:0]  mem_bhw;
    logic        mem_wr_nrd;
    logic [31:0] mem_adr;
    logic [31:0] mem_data;
    logic [31:0] mem_dataout;
    logic        mem_send;

    modport master (
        input  i_req, i_adr, d_req, d_wr_nrd, d_bhw, d_adr, d_wdata, mem_dataout, mem_send,
        output i_rdata, i_done, i_err, d_rdata, d_done, d_err,
               mem_request, mem_bhw, mem_wr_nrd, mem_adr, mem_data
    );

    modport slave (
        output i_req, i_adr, d_req, d_wr_nrd, d_bhw, d_adr, d_wdata, mem_dataout, mem_send,
        input  i_rdata, i_done, i_err, d_rdata, d_done, d_err,
               mem_request, mem_bhw, mem_wr_nrd, mem_adr, mem_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
//----------------------------------------------------------------------
// mem_arb_rr: two-way round-robin picker holding the last grant (rev 1.0)
//----------------------------------------------------------------------
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_i,
    input  logic  req_d,
    input  logic  update,
    output logic  any,
    output port_t winner
);

    port_t last_grant;

    always_comb begin
        winner = PORT_I;
        if (req_i && req_d) begin
            winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req_d) begin
            winner = PORT_D;
        end
    end

    assign any = req_i | req_d;

    // Reset to DATA so that fetch wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_D;
        end else if (update && any) begin
            last_grant <= winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------
// mem_arbiter: fetch / load-store sequencer in front of mainMemory (rev 1.0)
//----------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          nRESET,
    mem_arbiter_if.master bus
);

    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    logic [2:0]    state;
    port_t         owner;
    logic          timed_out;
    logic [7:0]    tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic          issue_req;
    logic          cmd_wr;
    logic [2:0]    cmd_bhw;
    logic [31:0]   cmd_adr;
    logic [31:0]   cmd_data;
    logic [31:0]   i_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          any_req;
    logic          cmd_illegal;
    port_t         winner;

    mem_arb_rr u_rr (
        .clk    (CLK),
        .rst_n  (nRESET),
        .req_i  (bus.i_req),
        .req_d  (bus.d_req),
        .update (state == ST_IDLE),
        .any    (any_req),
        .winner (winner)
    );

    always_comb begin
        cmd_illegal = 1'b0;
        if (winner == PORT_I) begin
            cmd_illegal = (bus.i_adr[1:0] != 2'b00);
        end else begin
            case (bus.d_bhw)
                BHW_BYTE: cmd_illegal = 1'b0;
                BHW_HALF: cmd_illegal = bus.d_adr[0];
                BHW_WORD: cmd_illegal = (bus.d_adr[1:0] != 2'b00);
                default:  cmd_illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= ST_IDLE;
            owner     <= PORT_I;
            timed_out <= 1'b0;
            tmo_cnt   <= 8'd0;
            gap_cnt   <= '0;
            issue_req <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_bhw   <= 3'd0;
            cmd_adr   <= 32'd0;
            cmd_data  <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        timed_out <= 1'b0;
                        tmo_cnt   <= 8'd0;
                        if (winner == PORT_I) begin
                            cmd_bhw  <= BHW_WORD;
                            cmd_wr   <= 1'b0;
                            cmd_adr  <= bus.i_adr;
                            cmd_data <= 32'd0;
                        end else begin
                            cmd_bhw  <= bus.d_bhw;
                            cmd_wr   <= bus.d_wr_nrd;
                            cmd_adr  <= bus.d_adr;
                            cmd_data <= bus.d_wdata;
                        end
                        // Illegal commands never touch the memory port.
                        if (cmd_illegal) begin
                            state <= ST_ERR;
                        end else begin
                            state     <= ST_ISSUE;
                            issue_req <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_send) begin
                        issue_req <= 1'b0;
                        state     <= ST_RESP;
                        if (!cmd_wr) begin
                            if (owner == PORT_I) begin
                                i_rdata_q <= bus.mem_dataout;
                            end else begin
                                d_rdata_q <= zext_data(cmd_bhw, bus.mem_dataout);
                            end
                        end
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        issue_req <= 1'b0;
                        timed_out <= 1'b1;
                        state     <= ST_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                end
                ST_ERR: begin
                    // A hung memory still needs its send edge detector rearmed.
                    if (timed_out) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_request = issue_req;
    assign bus.mem_bhw     = cmd_bhw;
    assign bus.mem_wr_nrd  = cmd_wr;
    assign bus.mem_adr     = cmd_adr;
    assign bus.mem_data    = cmd_data;
    assign bus.i_rdata     = i_rdata_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.i_done      = (state == ST_RESP) && (owner == PORT_I);
    assign bus.d_done      = (state == ST_RESP) && (owner == PORT_D);
    assign bus.i_err       = (state == ST_ERR)  && (owner == PORT_I);
    assign bus.d_err       = (state == ST_ERR)  && (owner == PORT_D);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------
// tb_mem_arbiter: randomized self-checking bench with a byte-level memory model (rev 1.0)
//----------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TMO = 16;
    localparam int GAP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
        .CLK    (clk),
        .nRESET (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem_bytes [int];
    bit          mem_never = 1'b0;
    logic [31:0] acc_adr [$];
    logic [31:0] acc_dat [$];
    logic [2:0]  acc_bhw [$];
    logic        acc_wr  [$];

    int rises = 0, high_cnt = 0, pulses = 0, multi_viol = 0, stab_viol = 0;
    int low_run = 0, min_low = 1000;
    bit seen_fall = 1'b0, prev_req = 1'b0;
    logic [67:0] prev_cmd = '0;

    function automatic logic [7:0] byte_at(input int a);
        if (mem_bytes.exists(a)) return mem_bytes[a];
        return 8'(a * 37 + 11);
    endfunction

    function automatic int nbytes(input logic [2:0] bhw);
        if (bhw == 3'b001) return 1;
        if (bhw == 3'b010) return 2;
        return 4;
    endfunction

    // Reference read: the addressed bytes, little-endian, zero-extended.
    function automatic logic [31:0] exp_read(input logic [31:0] adr, input logic [2:0] bhw);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nbytes(bhw); i++) v[8*i +: 8] = byte_at(int'(adr) + i);
        return v;
    endfunction

    // mainMemory: answers after 0..3 cycles, upper read bytes are junk.
    initial begin : mem_model
        int          wait_left;
        bit          active;
        logic [31:0] v;
        active = 1'b0;
        wait_left = 0;
        bus.mem_send = 1'b0;
        bus.mem_dataout = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_send = 1'b0;
            if (!rst_n || !bus.mem_request) begin
                active = 1'b0;
            end else if (!mem_never) begin
                if (!active) begin
                    active = 1'b1;
                    wait_left = int'($urandom_range(0, 3));
                end
                if (wait_left == 0) begin
                    acc_adr.push_back(bus.mem_adr);
                    acc_dat.push_back(bus.mem_data);
                    acc_bhw.push_back(bus.mem_bhw);
                    acc_wr.push_back(bus.mem_wr_nrd);
                    if (bus.mem_wr_nrd) begin
                        for (int i = 0; i < nbytes(bus.mem_bhw); i++)
                            mem_bytes[int'(bus.mem_adr) + i] = bus.mem_data[8*i +: 8];
                    end else begin
                        v = $urandom;
                        for (int i = 0; i < nbytes(bus.mem_bhw); i++)
                            v[8*i +: 8] = byte_at(int'(bus.mem_adr) + i);
                        bus.mem_dataout = v;
                    end
                    bus.mem_send = 1'b1;
                    wait_left = -1;
                end else if (wait_left > 0) begin
                    wait_left--;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (int'(bus.i_done) + int'(bus.i_err) + int'(bus.d_done) + int'(bus.d_err) > 1) multi_viol++;
            if (bus.i_done | bus.i_err | bus.d_done | bus.d_err) pulses++;
            if (bus.mem_request) begin
                high_cnt++;
                if (prev_req && ({bus.mem_bhw, bus.mem_wr_nrd, bus.mem_adr, bus.mem_data} !== prev_cmd)) stab_viol++;
                if (!prev_req) begin
                    rises++;
                    if (seen_fall && low_run < min_low) min_low = low_run;
                end
            end else begin
                if (prev_req) begin
                    seen_fall = 1'b1;
                    low_run = 0;
                end
                low_run++;
            end
            prev_req = bus.mem_request;
            prev_cmd = {bus.mem_bhw, bus.mem_wr_nrd, bus.mem_adr, bus.mem_data};
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end

    task automatic clear_gap_metric();
        seen_fall = 1'b0;
        min_low = 1000;
    endtask

    task automatic run_txn(input bit is_d, input logic [31:0] adr, input bit wr, input logic [2:0] bhw,
                           input logic [31:0] wdata, output bit done, output bit err, output int lat);
        done = 1'b0;
        err  = 1'b0;
        lat  = 0;
        if (is_d) begin
            bus.d_wr_nrd = wr;
            bus.d_bhw    = bhw;
            bus.d_adr    = adr;
            bus.d_wdata  = wdata;
            bus.d_req    = 1'b1;
        end else begin
            bus.i_adr = adr;
            bus.i_req = 1'b1;
        end
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (is_d ? (bus.d_done | bus.d_err) : (bus.i_done | bus.i_err)) begin
                done = is_d ? bus.d_done : bus.i_done;
                err  = is_d ? bus.d_err  : bus.i_err;
                lat  = k;
                break;
            end
        end
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_request, bus.i_done, bus.i_err, bus.d_done, bus.d_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.mem_request, bus.i_done, bus.i_err, bus.d_done, bus.d_err});
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'd0) begin
            failures++;
            $display("FAIL reset_rdata got i=%h d=%h exp=0", bus.i_rdata, bus.d_rdata);
        end
        checks++;
        if ({bus.mem_bhw, bus.mem_wr_nrd, bus.mem_adr, bus.mem_data} !== 68'd0) begin
            failures++;
            $display("FAIL reset_mem got bhw=%b wr=%b adr=%h data=%h exp=0", bus.mem_bhw, bus.mem_wr_nrd, bus.mem_adr, bus.mem_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int n0, ndone, dp;
        mem_bytes[16] = 8'h44; mem_bytes[17] = 8'h33; mem_bytes[18] = 8'h22; mem_bytes[19] = 8'h11;
        clear_gap_metric();
        n0 = acc_adr.size();
        ndone = 0;
        dp = 0;
        bus.i_adr = 32'h10;
        bus.i_req = 1'b1;
        for (int k = 0; k < 100 && ndone < 2; k++) begin
            @(negedge clk);
            if (bus.i_done) ndone++;
            if (bus.d_done | bus.d_err | bus.i_err) dp++;
        end
        bus.i_req = 1'b0;
        checks++;
        if (ndone !== 2 || dp !== 0) begin
            failures++;
            $display("FAIL fetch_done got i_done=%0d other=%0d exp=2,0", ndone, dp);
        end
        checks++;
        if (bus.i_rdata !== 32'h11223344) begin
            failures++;
            $display("FAIL fetch_rdata got=%h exp=11223344", bus.i_rdata);
        end
        checks++;
        if (acc_adr.size() !== n0 + 2 || acc_bhw[n0] !== BHW_WORD || acc_wr[n0] !== 1'b0 || acc_adr[n0] !== 32'h10) begin
            failures++;
            $display("FAIL fetch_cmd got n=%0d bhw=%b wr=%b adr=%h exp=%0d,100,0,10",
                     acc_adr.size() - n0, acc_bhw[n0], acc_wr[n0], acc_adr[n0], 2);
        end
        checks++;
        if (min_low !== GAP + 2) begin
            failures++;
            $display("FAIL fetch_gap got low cycles=%0d exp=%0d", min_low, GAP + 2);
        end
    endtask

    task automatic test_data_rw();
        bit done, err;
        int lat, n0;
        logic [31:0] d_prev;
        d_prev = bus.d_rdata;
        n0 = acc_adr.size();
        run_txn(1'b1, 32'h20, 1'b1, BHW_HALF, 32'h0000ABCD, done, err, lat);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || bus.d_rdata !== d_prev) begin
            failures++;
            $display("FAIL write_half got done=%b err=%b d_rdata=%h exp 1,0,%h", done, err, bus.d_rdata, d_prev);
        end
        checks++;
        if (acc_adr.size() !== n0 + 1 || acc_adr[n0] !== 32'h20 || acc_bhw[n0] !== BHW_HALF || acc_wr[n0] !== 1'b1 || acc_dat[n0] !== 32'h0000ABCD) begin
            failures++;
            $display("FAIL write_cmd got adr=%h bhw=%b wr=%b data=%h exp 20,010,1,0000abcd", acc_adr[n0], acc_bhw[n0], acc_wr[n0], acc_dat[n0]);
        end
        run_txn(1'b1, 32'h20, 1'b0, BHW_HALF, 32'h0, done, err, lat);
        checks++;
        if (done !== 1'b1 || bus.d_rdata !== 32'h0000ABCD) begin
            failures++;
            $display("FAIL read_half got done=%b d_rdata=%h exp 1,0000abcd", done, bus.d_rdata);
        end
    endtask

    task automatic test_random();
        bit is_d, wr, illegal, done, err;
        int lat, a0, sel;
        logic [31:0] adr, wd, exp, i_prev, d_prev;
        logic [2:0] bhw;
        for (int n = 0; n < 30; n++) begin
            is_d = 1'($urandom_range(0, 1));
            adr  = 32'h100 + $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) adr = adr & ~32'h3;
            wd   = $urandom;
            sel  = int'($urandom_range(0, 7));
            bhw  = !is_d ? BHW_WORD : (sel == 0) ? 3'b011 : (sel == 1) ? 3'b000 :
                   (sel < 4) ? BHW_BYTE : (sel < 6) ? BHW_HALF : BHW_WORD;
            wr   = is_d && ($urandom_range(0, 1) == 1);
            illegal = !(bhw == 3'b001 || bhw == 3'b010 || bhw == 3'b100) ||
                      (bhw == 3'b010 && adr[0]) || (bhw == 3'b100 && adr[1:0] != 2'b00);
            exp    = exp_read(adr, bhw);
            i_prev = bus.i_rdata;
            d_prev = bus.d_rdata;
            a0     = acc_adr.size();
            run_txn(is_d, adr, wr, bhw, wd, done, err, lat);
            checks++;
            if ({done, err} !== {!illegal, illegal}) begin
                failures++;
                $display("FAIL rnd_status n=%0d port=%0d adr=%h bhw=%b got done=%b err=%b exp illegal=%b", n, is_d, adr, bhw, done, err, illegal);
            end
            checks++;
            if (illegal) begin
                if (acc_adr.size() !== a0) begin
                    failures++;
                    $display("FAIL rnd_noacc n=%0d got accesses=%0d exp=0", n, acc_adr.size() - a0);
                end
            end else if (acc_adr.size() !== a0 + 1 || acc_adr[a0] !== adr || acc_bhw[a0] !== bhw || acc_wr[a0] !== wr) begin
                failures++;
                $display("FAIL rnd_cmd n=%0d got adr=%h bhw=%b wr=%b exp %h,%b,%b", n, acc_adr[a0], acc_bhw[a0], acc_wr[a0], adr, bhw, wr);
            end
            if (!illegal) begin
                checks++;
                if (wr) begin
                    if (acc_dat[a0] !== wd || bus.d_rdata !== d_prev) begin
                        failures++;
                        $display("FAIL rnd_write n=%0d got data=%h d_rdata=%h exp %h,%h", n, acc_dat[a0], bus.d_rdata, wd, d_prev);
                    end
                end else if (is_d) begin
                    if (bus.d_rdata !== exp || bus.i_rdata !== i_prev) begin
                        failures++;
                        $display("FAIL rnd_dread n=%0d got d=%h i=%h exp %h,%h", n, bus.d_rdata, bus.i_rdata, exp, i_prev);
                    end
                end else if (bus.i_rdata !== exp || bus.d_rdata !== d_prev) begin
                    failures++;
                    $display("FAIL rnd_fetch n=%0d got i=%h d=%h exp %h,%h", n, bus.i_rdata, bus.d_rdata, exp, d_prev);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt, r0;
        logic [3:0] order;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_gap_metric();
        r0 = rises;
        cnt = 0;
        order = 4'b0;
        bus.i_adr = 32'h40;
        bus.d_adr = 32'h80; bus.d_bhw = BHW_WORD; bus.d_wr_nrd = 1'b0; bus.d_wdata = 32'h0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int k = 0; k < 300 && cnt < 4; k++) begin
            @(negedge clk);
            if (bus.i_done) begin order[cnt] = 1'b0; cnt++; end
            else if (bus.d_done) begin order[cnt] = 1'b1; cnt++; end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (GAP + 4) @(negedge clk);
        checks++;
        if (cnt !== 4 || order !== 4'b1010) begin
            failures++;
            $display("FAIL rr_order got n=%0d order(lsb first)=%b exp 4,1010", cnt, order);
        end
        checks++;
        if (rises - r0 !== 4 || min_low < GAP + 2) begin
            failures++;
            $display("FAIL rr_bursts got bursts=%0d min_low=%0d exp 4,>=%0d", rises - r0, min_low, GAP + 2);
        end
        checks++;
        if (bus.i_rdata !== exp_read(32'h40, BHW_WORD) || bus.d_rdata !== exp_read(32'h80, BHW_WORD)) begin
            failures++;
            $display("FAIL rr_data got i=%h d=%h exp %h,%h", bus.i_rdata, bus.d_rdata, exp_read(32'h40, BHW_WORD), exp_read(32'h80, BHW_WORD));
        end
    endtask

    task automatic test_misaligned();
        bit done, err;
        int lat, r0;
        logic [31:0] adr_t [3];
        logic [2:0]  bhw_t [3];
        adr_t[0] = 32'h22; bhw_t[0] = 3'b100;
        adr_t[1] = 32'h20; bhw_t[1] = 3'b011;
        adr_t[2] = 32'h21; bhw_t[2] = 3'b010;
        for (int c = 0; c < 3; c++) begin
            repeat (GAP + 3) @(negedge clk);
            r0 = rises;
            run_txn(1'b1, adr_t[c], 1'b0, bhw_t[c], 32'h0, done, err, lat);
            checks++;
            if (err !== 1'b1 || done !== 1'b0 || lat > 2 || rises !== r0) begin
                failures++;
                $display("FAIL misaligned case=%0d got err=%b done=%b lat=%0d bursts=%0d exp 1,0,<=2,0", c, err, done, lat, rises - r0);
            end
        end
    endtask

    task automatic test_timeout();
        bit done, err;
        int lat, h0, a0, k;
        logic [31:0] i_prev;
        repeat (GAP + 3) @(negedge clk);
        mem_never = 1'b1;
        h0 = high_cnt;
        a0 = acc_adr.size();
        i_prev = bus.i_rdata;
        run_txn(1'b0, 32'h30, 1'b0, BHW_WORD, 32'h0, done, err, lat);
        mem_never = 1'b0;
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || lat !== TMO + 1) begin
            failures++;
            $display("FAIL timeout_err got err=%b done=%b lat=%0d exp 1,0,%0d", err, done, lat, TMO + 1);
        end
        checks++;
        if (high_cnt - h0 !== TMO || acc_adr.size() !== a0 || bus.i_rdata !== i_prev) begin
            failures++;
            $display("FAIL timeout_req got high=%0d acc=%0d i_rdata=%h exp %0d,0,%h", high_cnt - h0, acc_adr.size() - a0, bus.i_rdata, TMO, i_prev);
        end
        bus.i_adr = 32'h10;
        bus.i_req = 1'b1;
        k = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            k++;
            if (bus.mem_request) break;
        end
        checks++;
        if (k !== GAP + 2) begin
            failures++;
            $display("FAIL timeout_gap got cycles to next request=%0d exp=%0d", k, GAP + 2);
        end
        for (int j = 0; j < 40 && !bus.i_done; j++) @(negedge clk);
        bus.i_req = 1'b0;
        checks++;
        if (bus.i_rdata !== 32'h11223344) begin
            failures++;
            $display("FAIL timeout_recover got i_rdata=%h exp 11223344", bus.i_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit done, err;
        int lat, k, p0;
        repeat (GAP + 3) @(negedge clk);
        mem_never = 1'b1;
        bus.i_adr = 32'h30;
        bus.i_req = 1'b1;
        k = 0;
        while (!bus.mem_request && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.mem_request !== 1'b1) begin
            failures++;
            $display("FAIL rmid_issue got mem_request=%b exp 1", bus.mem_request);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_request !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async got mem_request=%b exp 0", bus.mem_request);
        end
        bus.i_req = 1'b0;
        p0 = pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mem_never = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pulses !== p0 || bus.i_rdata !== 32'd0) begin
            failures++;
            $display("FAIL rmid_quiet got pulses=%0d i_rdata=%h exp 0,0", pulses - p0, bus.i_rdata);
        end
        run_txn(1'b0, 32'h10, 1'b0, BHW_WORD, 32'h0, done, err, lat);
        checks++;
        if (done !== 1'b1 || bus.i_rdata !== 32'h11223344) begin
            failures++;
            $display("FAIL rmid_fetch got done=%b i_rdata=%h exp 1,11223344", done, bus.i_rdata);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (multi_viol !== 0) begin
            failures++;
            $display("FAIL onehot_pulses got overlapping cycles=%0d exp 0", multi_viol);
        end
        checks++;
        if (stab_viol !== 0) begin
            failures++;
            $display("FAIL cmd_stable got changes during request=%0d exp 0", stab_viol);
        end
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_adr = 32'd0;
        bus.d_req = 1'b0; bus.d_wr_nrd = 1'b0; bus.d_bhw = 3'd0; bus.d_adr = 32'd0; bus.d_wdata = 32'd0;
        test_reset();
        test_fetch();
        test_data_rw();
        test_random();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
